// File: rtl/dpc_console_pkg.sv
// Shared types and default sizes for the DekatronPC console bridge.
package dpc_console_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Handshake FSM: one ack cycle per transfer, then wait for the core to drop its request.
  typedef enum logic [1:0] {
    IDLE,
    OUT_ACK,
    IN_ACK,
    WAIT_REL
  } console_state_t;

  // Occupancy counters need one extra bit to tell "full" apart from "empty".
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dpc_console_bridge_if.sv
// Core-side handshake and host-side byte-stream signals of the console bridge.
interface dpc_console_bridge_if
  import dpc_console_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = cnt_width(DEFAULT_FIFO_DEPTH)
);

  // Core side
  logic                  Cout;
  logic [DATA_WIDTH-1:0] stdout;
  logic                  CinReq;
  logic [DATA_WIDTH-1:0] stdin;
  logic                  CioAcq;

  // Host side
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;

  // Status
  logic [CNT_WIDTH-1:0]  rx_count;
  logic [CNT_WIDTH-1:0]  tx_count;
  logic                  overrun;

  // The bridge itself.
  modport slave (
    input  Cout, stdout, CinReq, rx_valid, rx_data, tx_ready,
    output stdin, CioAcq, rx_ready, tx_valid, tx_data, rx_count, tx_count, overrun
  );

  // Whoever drives the core and host sides (core model, host front end, bench).
  modport master (
    output Cout, stdout, CinReq, rx_valid, rx_data, tx_ready,
    input  stdin, CioAcq, rx_ready, tx_valid, tx_data, rx_count, tx_count, overrun
  );

endinterface

// File: rtl/console_fifo.sv
// Synchronous registered FIFO: no fall-through, blocked push when full,
// ignored pop when empty, power-of-two depth with naturally wrapping pointers.
module console_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH),
  localparam int CNT_WIDTH  = PTR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Flags come from the count alone, so a same-cycle pop never frees a full slot.
  assign full    = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count define validity,
  // and leaving it unreset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (do_push && !do_pop)      count <= count + CNT_WIDTH'(1);
      else if (do_pop && !do_push) count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dpc_console_bridge.sv
// DekatronPC console bridge: buffers core output bytes toward the host (TX)
// and host bytes toward the core (RX), and generates the single CioAcq pulse
// the core waits on in both directions.
module dpc_console_bridge
  import dpc_console_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input logic                  Clk,
  input logic                  Rst_n,
  dpc_console_bridge_if.slave  bus
);

  console_state_t        state;
  logic                  cio_acq;
  logic [DATA_WIDTH-1:0] stdin_q;
  logic                  overrun_q;

  logic                  tx_full;
  logic                  tx_empty;
  logic [CNT_WIDTH-1:0]  tx_count_w;
  logic                  rx_full;
  logic                  rx_empty;
  logic [DATA_WIDTH-1:0] rx_head;
  logic [CNT_WIDTH-1:0]  rx_count_w;

  logic                  out_go;
  logic                  in_go;

  // Transfer decisions in IDLE; output wins, input only when no output is taken.
  assign out_go = (state == IDLE) && bus.Cout && !tx_full;
  assign in_go  = (state == IDLE) && !out_go && bus.CinReq && !rx_empty;

  console_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push      (out_go),
    .push_data (bus.stdout),
    .pop       (bus.tx_ready),
    .head      (bus.tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count_w)
  );

  console_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push      (bus.rx_valid),
    .push_data (bus.rx_data),
    .pop       (in_go),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count_w)
  );

  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;
  assign bus.tx_count = tx_count_w;
  assign bus.rx_count = rx_count_w;
  assign bus.stdin    = stdin_q;
  assign bus.CioAcq   = cio_acq;
  assign bus.overrun  = overrun_q;

  // Handshake FSM with registered ack and stdin; ack is high exactly in OUT_ACK/IN_ACK.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cio_acq <= 1'b0;
      stdin_q <= '0;
    end else begin
      cio_acq <= 1'b0;
      case (state)
        IDLE: begin
          if (out_go) begin
            state   <= OUT_ACK;
            cio_acq <= 1'b1;
          end else if (in_go) begin
            stdin_q <= rx_head;
            state   <= IN_ACK;
            cio_acq <= 1'b1;
          end
        end
        OUT_ACK, IN_ACK: state <= WAIT_REL;
        WAIT_REL: begin
          // Holding here until both requests drop stops a level request from transferring twice.
          if (!bus.Cout && !bus.CinReq) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag for host bytes offered while the RX FIFO was full (those bytes are dropped).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                      overrun_q <= 1'b0;
    else if (bus.rx_valid && rx_full) overrun_q <= 1'b1;
  end

endmodule
